activation_skew_feeder: RTL
===========================

Name: activation_skew_feeder

Overview:
- Upstream stage of the systolic PE array. Drives the activation_i, ACTIVATION_ENABLE_i and END_SIGNAL_i inputs of the left-edge process_element in each of ROWS array rows.
- Accepts one activation column per cycle (one FP16 value per row, same K index) over a valid/ready handshake.
- Re-times the column into a diagonal wavefront: row r is delayed r cycles relative to row 0.
- Closes each vector with a per-row END pulse, stalling input until the last row has ended.

Parameters:
- ROWS, 4, number of PE rows fed (≥1)
- DATA_WIDTH, 16, activation width (FP16 bit pattern, never interpreted)
- MAX_LEN, 64, maximum accepted beats per vector; sizes beat_cnt_o

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_data  in  ROWS*DATA_WIDTH  column; row r at bits [r*DATA_WIDTH +: DATA_WIDTH]
- in_valid  in  1  column valid
- in_last  in  1  column is final K element of vector (qualified by in_valid)
- in_ready  out  1  feeder can accept column
- act_o  out  ROWS*DATA_WIDTH  per-row activation to PE row r
- act_en_o  out  ROWS  per-row ACTIVATION_ENABLE
- end_o  out  ROWS  per-row END_SIGNAL pulse
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse, vector fully flushed
- beat_cnt_o  out  $clog2(MAX_LEN+1)  beats accepted in current vector

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset: state IDLE; act_o=0, act_en_o=0, end_o=0, busy_o=0, done_o=0, beat_cnt_o=0; all skew registers cleared; in_ready=1 in the cycle following the reset edge.
- Reset asserted mid-vector discards everything in flight; no end_o or done_o is emitted for the aborted vector.
- Accept: a beat transfers at an edge where in_valid && in_ready. in_ready is 1 in IDLE and STREAM and 0 in FLUSH (combinational from state only).
- Skew: a beat accepted at edge t appears on row r from edge t+r onward, for exactly one cycle, with act_en_o[r]=1. Row 0 latency is 1 register.
- Implementation: row r uses an r-deep shift of {data, en, end} behind a common input register.
- Bubbles: a cycle with no accepted beat (in_valid=0 in STREAM) propagates as act_en_o[r]=0 in the matching skewed slot. act_o[r] is forced to 0 whenever act_en_o[r]=0.
- End: in_last accepted at edge t causes end_o[r]=1 for one cycle after edge t+r+1, i.e. the cycle immediately after row r's last enable. act_en_o[r]=0 in that cycle.
- FSM states:
  - IDLE: accepted beat with in_last=0 goes to STREAM; accepted beat with in_last=1 goes to FLUSH.
  - STREAM: accepted beat with in_last=1 goes to FLUSH; otherwise stays in STREAM.
  - FLUSH: a down-counter is loaded with ROWS-1 on entry and decrements each cycle. At the edge where it is 0, go to IDLE with done_o=1 in the same cycle as end_o[ROWS-1].
- Flush timing: FLUSH occupies exactly ROWS cycles.
- Back-to-back vectors: a new vector can be accepted at edge t+ROWS+1, which cannot collide with the previous vector's end pulses on any row.
- beat_cnt_o: increments on each accepted beat and saturates at MAX_LEN. It is cleared on the edge entering IDLE from FLUSH and holds its value during FLUSH.
- Beats accepted beyond MAX_LEN are still forwarded; only the count saturates.
- ROWS=1: FLUSH lasts 1 cycle; done_o coincides with end_o[0].
- Output registers: all outputs are registered except in_ready and busy_o, which are decoded directly from state.

Test Plan:
- ROWS=4, 4 consecutive beats, in_last on beat 4. Row 0 data 4010,3C80,3C80,3C80; row r data = row0 data with bit r flipped.
  -> Row r enables are high in cycles r+1..r+4 after the first accept edge.
  -> end_o[r] pulses in cycle r+5; done_o pulses with end_o[3]; beat_cnt_o=4 before clearing.
- Same vector with in_valid=0 for one cycle between beats 2 and 3.
  -> Each row shows a one-cycle act_en_o=0 bubble with act_o=0, shifted r cycles per row.
  -> end_o[r] is delayed by 1 cycle versus the no-bubble case.
- Single-beat vector (in_valid=1, in_last=1 in IDLE).
  -> FSM goes IDLE to FLUSH; each row gets one enable then one end pulse; in_ready=0 for 4 cycles.
- Back-to-back: second vector presented with in_valid held high throughout.
  -> in_ready=0 for exactly ROWS cycles; first beat of vector 2 is accepted on the cycle after done_o.
  -> On no row does an end_o pulse coincide with an act_en_o of vector 2.
- rst pulsed for one cycle during STREAM after 2 beats.
  -> All outputs are 0 from the next cycle; no end_o or done_o is emitted; in_ready=1; a new vector then behaves as in the first scenario.
- MAX_LEN=4, 6-beat vector.
  -> All 6 beats are forwarded on every row; beat_cnt_o saturates at 4; done_o still pulses normally.

Source files
------------

// File: rtl/activation_skew_feeder.sv
// activation_skew_feeder
// Upstream stage of the systolic PE array. Accepts one activation column per
// cycle over valid/ready and re-times it into a diagonal wavefront: row r of
// the column reaches the left-edge PE of row r delayed by r cycles. Each
// vector is closed with a per-row END pulse; input is stalled until the last
// row has seen its END.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_data         column, row r at [r*DATA_WIDTH +: DATA_WIDTH]
//   in_valid        column valid
//   in_last         column is the final K element of the vector
//   in_ready        feeder can accept a column (decoded from state)
//   act_o           per-row activation, zero whenever its enable is low
//   act_en_o        per-row ACTIVATION_ENABLE
//   end_o           per-row END_SIGNAL pulse
//   busy_o          vector in progress (decoded from state)
//   done_o          one-cycle pulse when the vector is fully flushed
//   beat_cnt_o      beats accepted in the current vector, saturating
module activation_skew_feeder #(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MAX_LEN    = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ROWS*DATA_WIDTH-1:0]     in_data,
   input  logic                           in_valid,
   input  logic                           in_last,
   output logic                           in_ready,
   output logic [ROWS*DATA_WIDTH-1:0]     act_o,
   output logic [ROWS-1:0]                act_en_o,
   output logic [ROWS-1:0]                end_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [$clog2(MAX_LEN+1)-1:0]   beat_cnt_o
);

   localparam int unsigned BUS_W  = ROWS * DATA_WIDTH;
   localparam int unsigned CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned BEAT_W = $clog2(MAX_LEN + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] FLUSH  = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] flush_cnt;
   logic             accept;
   logic             flush_first;
   logic             flush_last;

   // Common input register feeding every row's skew line
   logic [BUS_W-1:0] in_d;
   logic             in_en;
   logic             in_end;

   assign in_ready    = (state != FLUSH);
   assign busy_o      = (state != IDLE);
   assign accept      = in_valid && in_ready;
   assign flush_first = (state == FLUSH) && (flush_cnt == CNT_W'(ROWS - 1));
   assign flush_last  = (state == FLUSH) && (flush_cnt == '0);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, STREAM: begin
            if (accept) begin
               state_nxt = in_last ? FLUSH : STREAM;
            end
         end
         FLUSH: begin
            if (flush_cnt == '0) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Flush counter, done pulse and beat counter
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt  <= '0;
         done_o     <= 1'b0;
         beat_cnt_o <= '0;
      end else begin
         // Held at ROWS-1 outside FLUSH so it is already loaded on entry
         if (state != FLUSH) begin
            flush_cnt <= CNT_W'(ROWS - 1);
         end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - CNT_W'(1);
         end
         done_o <= flush_last;
         if (flush_last) begin
            beat_cnt_o <= '0;
         end else if (accept && (beat_cnt_o != BEAT_W'(MAX_LEN))) begin
            beat_cnt_o <= beat_cnt_o + BEAT_W'(1);
         end
      end
   end

   // Input register; data is zeroed on bubbles so act_o is 0 whenever enable is 0.
   // The END slot is inserted in the first FLUSH cycle, right behind the last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_d   <= '0;
         in_en  <= 1'b0;
         in_end <= 1'b0;
      end else begin
         in_d   <= accept ? in_data : '0;
         in_en  <= accept;
         in_end <= flush_first;
      end
   end

   // Per-row skew: row r sits r registers behind the common input register
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      if (r == 0) begin : g_direct
         assign act_o[0 +: DATA_WIDTH] = in_d[0 +: DATA_WIDTH];
         assign act_en_o[0]            = in_en;
         assign end_o[0]               = in_end;
      end else begin : g_skew
         logic [DATA_WIDTH-1:0] sd [r];
         logic [r-1:0]          se;
         logic [r-1:0]          sn;

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < r; k++) begin
                  sd[k] <= '0;
               end
               se <= '0;
               sn <= '0;
            end else begin
               sd[0] <= in_d[r*DATA_WIDTH +: DATA_WIDTH];
               se[0] <= in_en;
               sn[0] <= in_end;
               for (int k = 1; k < r; k++) begin
                  sd[k] <= sd[k-1];
                  se[k] <= se[k-1];
                  sn[k] <= sn[k-1];
               end
            end
         end

         assign act_o[r*DATA_WIDTH +: DATA_WIDTH] = sd[r-1];
         assign act_en_o[r]                       = se[r-1];
         assign end_o[r]                          = sn[r-1];
      end
   end

endmodule
